// File: rtl/axis_src_pkg.sv
// rtl/axis_src_pkg.sv - shared types, constants and data folding for the packet source
package axis_src_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Maps a raw LFSR value into the range 0..data_max by wrapping the excess.
  function automatic logic [15:0] fold(input logic [15:0] x, input int unsigned data_max);
    if (32'(x) <= data_max) begin
      return x;
    end
    return 16'(32'(x) - data_max - 32'd1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit right-shifting Galois LFSR with load and advance controls
module lfsr16
  import axis_src_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value: a load wins over an advance; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_val;
    end else if (adv) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    end
  end

  // State register; reset restores the non-zero default so the sequence never locks up.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/axis_pkt_source.sv
// rtl/axis_pkt_source.sv - pseudo-random packet generator on a valid/ready stream
module axis_pkt_source
  import axis_src_pkg::*;
#(
  parameter int          STREAM_WIDTH = 32,
  parameter int unsigned DATA_MAX     = 65000
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [7:0]              pkt_len,
  input  logic [15:0]             seed,
  input  logic [3:0]              gap,
  output logic [STREAM_WIDTH-1:0] TDATA,
  output logic                    TVALID,
  output logic                    TLAST,
  input  logic                    TREADY,
  output logic                    busy,
  output logic [15:0]             exp_max,
  output logic                    exp_valid,
  output logic [15:0]             pkt_count
);

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  beat_q, beat_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [15:0] max_q, max_d;
  logic [15:0] exp_max_q, exp_max_d;
  logic [15:0] pkt_count_q, pkt_count_d;

  logic        lfsr_load;
  logic        lfsr_adv;
  logic [15:0] lfsr_val;
  logic [15:0] load_val;
  logic [15:0] beat_val;
  logic [15:0] max_next;
  logic        is_last;

  assign load_val = (seed == 16'd0) ? DEFAULT_SEED : seed;
  assign beat_val = fold(lfsr_val, DATA_MAX);
  assign max_next = (beat_val > max_q) ? beat_val : max_q;
  assign is_last  = (beat_q == (len_q - 8'd1));
  assign busy     = (state_q != IDLE);
  assign exp_max  = exp_max_q;
  assign pkt_count = pkt_count_q;

  lfsr16 u_lfsr (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .load     (lfsr_load),
    .load_val (load_val),
    .adv      (lfsr_adv),
    .q        (lfsr_val)
  );

  // Next-state and stream outputs; the completed-packet results are committed on
  // the last handshake so they are already visible while exp_valid strobes.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    beat_d      = beat_q;
    gcnt_d      = gcnt_q;
    max_d       = max_q;
    exp_max_d   = exp_max_q;
    pkt_count_d = pkt_count_q;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;
    TDATA       = '0;
    TVALID      = 1'b0;
    TLAST       = 1'b0;
    exp_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (pkt_len != 8'd0)) begin
          state_d   = SEND;
          len_d     = pkt_len;
          gap_d     = gap;
          beat_d    = 8'd0;
          max_d     = 16'd0;
          lfsr_load = 1'b1;
        end
      end
      SEND: begin
        TVALID      = 1'b1;
        TLAST       = is_last;
        TDATA[15:0] = beat_val;
        if (TREADY) begin
          lfsr_adv = 1'b1;
          max_d    = max_next;
          if (is_last) begin
            state_d     = DONE;
            exp_max_d   = max_next;
            pkt_count_d = pkt_count_q + 16'd1;
          end else begin
            beat_d = beat_q + 8'd1;
            if (gap_q != 4'd0) begin
              state_d = GAP;
              gcnt_d  = gap_q;
            end
          end
        end
      end
      GAP: begin
        if (gcnt_q <= 4'd1) begin
          state_d = SEND;
          gcnt_d  = 4'd0;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      DONE: begin
        exp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers; reset abandons any packet in flight and wins over start and handshakes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      len_q       <= 8'd0;
      gap_q       <= 4'd0;
      beat_q      <= 8'd0;
      gcnt_q      <= 4'd0;
      max_q       <= 16'd0;
      exp_max_q   <= 16'd0;
      pkt_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      beat_q      <= beat_d;
      gcnt_q      <= gcnt_d;
      max_q       <= max_d;
      exp_max_q   <= exp_max_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: doc/axis_pkt_source.md
AXIS_PKT_SOURCE -- requirements
Module: axis_pkt_source

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows.
- STREAM_WIDTH, 32: TDATA width; must be at least 16.
- DATA_MAX, 65000: largest value ever driven on TDATA.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows.
- ACLK, in, 1: single clock; all logic samples on the rising edge.
- ARESET, in, 1: reset, synchronous and active-high.
- start, in, 1: request one packet; sampled only in IDLE.
- pkt_len, in, 8: beats per packet; latched on accepted start.
- seed, in, 16: LFSR seed; latched on accepted start.
- gap, in, 4: idle (TVALID-low) cycles inserted between beats; latched on accepted start.
- TDATA, out, STREAM_WIDTH: stream data.
- TVALID, out, 1: stream valid.
- TLAST, out, 1: marks the final beat of a packet.
- TREADY, in, 1: downstream ready.
- busy, out, 1: high whenever state is not IDLE.
- exp_max, out, 16: maximum value sent in the last completed packet.
- exp_valid, out, 1: one-cycle strobe that exp_max has updated.
- pkt_count, out, 16: completed packets since reset; wraps at 0xFFFF to 0.

Function
REQ-003 The FSM SHALL have states IDLE, SEND, GAP and DONE, and reset into IDLE.
REQ-004 In IDLE, start=1 with pkt_len!=0 SHALL latch pkt_len, seed and gap and move to SEND on the next cycle.
- start with pkt_len=0 is ignored.
- start outside IDLE is ignored.
REQ-005 A seed of 0 SHALL be replaced by 16'hACE1, which avoids LFSR lockup.
REQ-006 The LFSR SHALL be 16-bit Galois, right-shift, with mask 16'hB400.
- If the lsb is 1: next = (lfsr>>1)^16'hB400.
- Otherwise: next = lfsr>>1.
REQ-007 Beat value SHALL be fold(lfsr), zero-extended to STREAM_WIDTH.
- fold(x) = x when x <= DATA_MAX.
- fold(x) = x - (DATA_MAX+1) otherwise.
REQ-008 The first beat SHALL carry fold(latched seed), and the LFSR SHALL advance only on a handshake (TVALID & TREADY).
REQ-009 In SEND, TVALID SHALL be 1.
- TDATA and TLAST stay stable while TREADY=0.
- TVALID never drops before a handshake.
REQ-010 TLAST SHALL be 1 only on beat index pkt_len-1, counting from 0.
REQ-011 After a non-last handshake:
- gap=0: stay in SEND, so back-to-back beats with no bubble.
- gap!=0: go to GAP with TVALID=0 for exactly gap cycles, then return to SEND.
REQ-012 On the last handshake the FSM SHALL go to DONE.
- DONE lasts one cycle: exp_valid=1, exp_max updated, pkt_count incremented.
- The FSM then returns to IDLE; the earliest next start is accepted in the cycle after DONE.
REQ-013 The running max SHALL be the unsigned 16-bit max over all handshaken beats of the current packet, cleared on an accepted start.
REQ-014 exp_max SHALL hold its value between packets and change only in DONE.
REQ-015 Latency SHALL be:
- start sampled at edge N gives the first TVALID=1 after edge N+1.
- The last handshake at edge M gives exp_valid=1 after edge M+1.
REQ-016 When TREADY is held 0 indefinitely, the block SHALL hold the current beat with no timeout and no data loss.

Reset
REQ-017 ARESET=1 at a rising edge SHALL, from the next cycle, force the following:
- State = IDLE; TVALID, TLAST, exp_valid, busy = 0.
- TDATA, exp_max, pkt_count, running max, beat counter, gap counter = 0.
- LFSR = 16'hACE1.
REQ-018 Reset mid-packet SHALL abandon the packet: no TLAST, no exp_valid, and pkt_count unchanged by the abandoned packet.
REQ-019 Reset SHALL take priority over start and over any handshake in the same cycle.

Structure
REQ-020 Package axis_src_pkg SHALL hold:
- the state enum (IDLE, SEND, GAP, DONE);
- LFSR_MASK=16'hB400, DEFAULT_SEED=16'hACE1;
- the fold() function.
REQ-021 A sub-module lfsr16 SHALL own the LFSR.
- Ports: ACLK, ARESET, load, load_val, adv, q.
- load takes priority over adv.
REQ-022 All other logic SHALL live in axis_pkt_source, with every register updated only on the ACLK rising edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios.
- Basic packet: seed=16'hACE1, pkt_len=3, gap=0, TREADY=1 -> TDATA 44257, 57968, 28984; TLAST on the third beat; exp_max=57968; pkt_count=1.
- Backpressure: same packet with TREADY=0 for 5 cycles at beat 2 -> 57968 held stable with TVALID=1 throughout; same three values; exp_max=57968.
- Gaps: gap=2, pkt_len=3 -> exactly 2 TVALID-low cycles between consecutive beats; 3 beats total.
- Boundaries:
  - pkt_len=0 start -> busy stays 0.
  - seed=0 -> first beat 44257.
  - pkt_len=1 -> single beat with TLAST=1.
- Reset mid-packet: ARESET pulsed after beat 1 of an 8-beat packet -> TVALID=0 the next cycle; no exp_valid; pkt_count=0; a new start then yields 44257 first.
- Protocol checker throughout, flagging any of:
  - TVALID dropping without a handshake;
  - TDATA or TLAST changing while TVALID & !TREADY;
  - any TDATA > 65000.
